kdtree_query_scheduler: RTL and testbench

KDTREE_QUERY_SCHEDULER -- requirements
Module: kdtree_query_scheduler

---
 rtl/kdtree_query_scheduler_pkg.sv | 24 ++
 rtl/kdtree_query_scheduler_if.sv | 55 +++++
 rtl/kdtree_query_scheduler_tag_pipe.sv | 45 ++++
 rtl/kdtree_query_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_kdtree_query_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kdtree_query_scheduler_pkg.sv
// rtl/kdtree_query_scheduler_pkg.sv - shared defaults, FSM states and tag type for the kd-tree scheduler
package kdtree_pkg;

  localparam int DEF_INTERNAL_WIDTH = 22;
  localparam int DEF_PATCH_WIDTH    = 55;
  localparam int DEF_ADDRESS_WIDTH  = 8;
  localparam int DEF_NUM_NODES      = 63;
  localparam int DEF_TREE_LATENCY   = 8;
  localparam int DEF_QIDX_WIDTH     = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_QUERY,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic                      valid;
    logic [DEF_QIDX_WIDTH-1:0] idx;
  } tag_t;

endpackage

// File: rtl/kdtree_query_scheduler_if.sv
// rtl/kdtree_query_scheduler_if.sv - job, node/query streams, tree and result signals of the scheduler
interface kdtree_query_scheduler_if #(
  parameter int INTERNAL_WIDTH = kdtree_pkg::DEF_INTERNAL_WIDTH,
  parameter int PATCH_WIDTH    = kdtree_pkg::DEF_PATCH_WIDTH,
  parameter int ADDRESS_WIDTH  = kdtree_pkg::DEF_ADDRESS_WIDTH,
  parameter int QIDX_WIDTH     = kdtree_pkg::DEF_QIDX_WIDTH
);
  logic                      start;
  logic [QIDX_WIDTH-1:0]     num_queries;
  logic                      node_valid;
  logic                      node_ready;
  logic [INTERNAL_WIDTH-1:0] node_data;
  logic                      q_valid;
  logic                      q_ready;
  logic [PATCH_WIDTH-1:0]    q_data;
  logic                      tree_fsm_enable;
  logic                      tree_sender_enable;
  logic [INTERNAL_WIDTH-1:0] tree_sender_data;
  logic                      tree_patch_en;
  logic                      tree_patch_two_en;
  logic [PATCH_WIDTH-1:0]    tree_patch_in;
  logic [PATCH_WIDTH-1:0]    tree_patch_in_two;
  logic [ADDRESS_WIDTH-1:0]  tree_leaf_index;
  logic [ADDRESS_WIDTH-1:0]  tree_leaf_index_two;
  logic                      tree_receiver_en;
  logic                      tree_receiver_two_en;
  logic                      res_valid;
  logic                      res_valid_two;
  logic [QIDX_WIDTH-1:0]     res_idx;
  logic [QIDX_WIDTH-1:0]     res_idx_two;
  logic [ADDRESS_WIDTH-1:0]  res_leaf;
  logic [ADDRESS_WIDTH-1:0]  res_leaf_two;
  logic                      busy;
  logic                      done;
  logic                      err;

  modport slave (
    input  start, num_queries, node_valid, node_data, q_valid, q_data,
           tree_leaf_index, tree_leaf_index_two, tree_receiver_en, tree_receiver_two_en,
    output node_ready, q_ready, tree_fsm_enable, tree_sender_enable, tree_sender_data,
           tree_patch_en, tree_patch_two_en, tree_patch_in, tree_patch_in_two,
           res_valid, res_valid_two, res_idx, res_idx_two, res_leaf, res_leaf_two,
           busy, done, err
  );

  modport master (
    output start, num_queries, node_valid, node_data, q_valid, q_data,
           tree_leaf_index, tree_leaf_index_two, tree_receiver_en, tree_receiver_two_en,
    input  node_ready, q_ready, tree_fsm_enable, tree_sender_enable, tree_sender_data,
           tree_patch_en, tree_patch_two_en, tree_patch_in, tree_patch_in_two,
           res_valid, res_valid_two, res_idx, res_idx_two, res_leaf, res_leaf_two,
           busy, done, err
  );

endinterface

// File: rtl/kdtree_query_scheduler_tag_pipe.sv
// rtl/kdtree_query_scheduler_tag_pipe.sv - fixed-latency {valid, idx} shadow of one tree lane
module kdtree_tag_pipe
  import kdtree_pkg::*;
#(
  parameter int DEPTH = DEF_TREE_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [DEF_QIDX_WIDTH-1:0] load_idx,
  output tag_t                      head,
  output logic                      occupied
);

  tag_t pipe_q [DEPTH];
  tag_t pipe_d [DEPTH];

  always_comb begin
    pipe_d[0].valid = load;
    pipe_d[0].idx   = load ? load_idx : '0;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign head = pipe_q[DEPTH-1];

  always_comb begin
    occupied = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied = occupied | pipe_q[i].valid;
    end
  end

endmodule

// File: rtl/kdtree_query_scheduler.sv
// rtl/kdtree_query_scheduler.sv - loads kd-tree node words, pairs queries onto two tree lanes, tags results
module kdtree_query_scheduler
  import kdtree_pkg::*;
#(
  parameter int INTERNAL_WIDTH = DEF_INTERNAL_WIDTH,
  parameter int PATCH_WIDTH    = DEF_PATCH_WIDTH,
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int NUM_NODES      = DEF_NUM_NODES,
  parameter int TREE_LATENCY   = DEF_TREE_LATENCY,
  parameter int QIDX_WIDTH     = DEF_QIDX_WIDTH
) (
  input logic                      clk,
  input logic                      rst_n,
  kdtree_query_scheduler_if.slave  bus
);

  localparam int NCW = $clog2(NUM_NODES + 1);
  localparam logic [NCW-1:0] NODE_LAST = NCW'(NUM_NODES - 1);

  state_t                  state_q, state_d;
  logic [NCW-1:0]          node_cnt_q, node_cnt_d;
  logic [QIDX_WIDTH-1:0]   num_q_q, num_q_d;
  logic [QIDX_WIDTH-1:0]   acc_cnt_q, acc_cnt_d;
  logic                    pair_valid_q, pair_valid_d;
  logic [PATCH_WIDTH-1:0]  pair_data_q, pair_data_d;
  logic [QIDX_WIDTH-1:0]   pair_idx_q, pair_idx_d;
  logic                    patch_en_q, patch_en_d;
  logic                    patch_two_en_q, patch_two_en_d;
  logic [PATCH_WIDTH-1:0]  patch_in_q, patch_in_d;
  logic [PATCH_WIDTH-1:0]  patch_in_two_q, patch_in_two_d;
  logic [QIDX_WIDTH-1:0]   idx0_q, idx0_d;
  logic [QIDX_WIDTH-1:0]   idx1_q, idx1_d;
  logic                    job_seen_q, job_seen_d;
  logic                    err_q, err_d;

  logic node_ready, fsm_en, sender_en, q_ready, busy, done, res_gate;
  logic [INTERNAL_WIDTH-1:0] sender_data;
  tag_t head0, head1;
  logic occ0, occ1;

  kdtree_tag_pipe #(.DEPTH(TREE_LATENCY)) u_tag_pipe0 (
    .clk(clk), .rst_n(rst_n), .load(patch_en_q), .load_idx(idx0_q),
    .head(head0), .occupied(occ0)
  );

  kdtree_tag_pipe #(.DEPTH(TREE_LATENCY)) u_tag_pipe1 (
    .clk(clk), .rst_n(rst_n), .load(patch_two_en_q), .load_idx(idx1_q),
    .head(head1), .occupied(occ1)
  );

  always_comb begin
    state_d        = state_q;
    node_cnt_d     = node_cnt_q;
    num_q_d        = num_q_q;
    acc_cnt_d      = acc_cnt_q;
    pair_valid_d   = pair_valid_q;
    pair_data_d    = pair_data_q;
    pair_idx_d     = pair_idx_q;
    patch_en_d     = 1'b0;
    patch_two_en_d = 1'b0;
    patch_in_d     = patch_in_q;
    patch_in_two_d = patch_in_two_q;
    idx0_d         = idx0_q;
    idx1_d         = idx1_q;
    job_seen_d     = job_seen_q;
    err_d          = err_q;
    node_ready     = 1'b0;
    fsm_en         = 1'b0;
    sender_en      = 1'b0;
    sender_data    = '0;
    q_ready        = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          state_d      = ST_LOAD;
          num_q_d      = bus.num_queries;
          node_cnt_d   = '0;
          acc_cnt_d    = '0;
          pair_valid_d = 1'b0;
          job_seen_d   = 1'b1;
        end
      end
      ST_LOAD: begin
        node_ready  = 1'b1;
        fsm_en      = 1'b1;
        sender_en   = bus.node_valid;
        sender_data = bus.node_data;
        if (bus.node_valid) begin
          node_cnt_d = node_cnt_q + 1'b1;
          if (node_cnt_q == NODE_LAST) state_d = ST_QUERY;
        end
      end
      ST_QUERY: begin
        // The pair register always frees on an odd accept, so only the count gates q_ready.
        q_ready = (acc_cnt_q < num_q_q);
        if (acc_cnt_q == num_q_q) begin
          state_d = ST_DRAIN;
        end else if (bus.q_valid) begin
          acc_cnt_d = acc_cnt_q + 1'b1;
          if (acc_cnt_q[0]) begin
            patch_en_d     = 1'b1;
            patch_two_en_d = 1'b1;
            patch_in_d     = pair_data_q;
            patch_in_two_d = bus.q_data;
            idx0_d         = pair_idx_q;
            idx1_d         = acc_cnt_q;
            pair_valid_d   = 1'b0;
          end else if (acc_cnt_q == (num_q_q - 1'b1)) begin
            patch_en_d = 1'b1;
            patch_in_d = bus.q_data;
            idx0_d     = acc_cnt_q;
          end else begin
            pair_valid_d = 1'b1;
            pair_data_d  = bus.q_data;
            pair_idx_d   = acc_cnt_q;
          end
        end
      end
      ST_DRAIN: begin
        if (!occ0 && !occ1 && !patch_en_q && !patch_two_en_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Results not covered by a tag are errors, but only once a job exists since reset.
    if (job_seen_q && ((bus.tree_receiver_en != head0.valid) ||
                       (bus.tree_receiver_two_en != head1.valid))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      node_cnt_q     <= '0;
      num_q_q        <= '0;
      acc_cnt_q      <= '0;
      pair_valid_q   <= 1'b0;
      pair_data_q    <= '0;
      pair_idx_q     <= '0;
      patch_en_q     <= 1'b0;
      patch_two_en_q <= 1'b0;
      patch_in_q     <= '0;
      patch_in_two_q <= '0;
      idx0_q         <= '0;
      idx1_q         <= '0;
      job_seen_q     <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      node_cnt_q     <= node_cnt_d;
      num_q_q        <= num_q_d;
      acc_cnt_q      <= acc_cnt_d;
      pair_valid_q   <= pair_valid_d;
      pair_data_q    <= pair_data_d;
      pair_idx_q     <= pair_idx_d;
      patch_en_q     <= patch_en_d;
      patch_two_en_q <= patch_two_en_d;
      patch_in_q     <= patch_in_d;
      patch_in_two_q <= patch_in_two_d;
      idx0_q         <= idx0_d;
      idx1_q         <= idx1_d;
      job_seen_q     <= job_seen_d;
      err_q          <= err_d;
    end
  end

  assign res_gate = (state_q == ST_QUERY) || (state_q == ST_DRAIN) || (state_q == ST_DONE);

  assign bus.node_ready         = node_ready;
  assign bus.q_ready            = q_ready;
  assign bus.tree_fsm_enable    = fsm_en;
  assign bus.tree_sender_enable = sender_en;
  assign bus.tree_sender_data   = sender_data;
  assign bus.tree_patch_en      = patch_en_q;
  assign bus.tree_patch_two_en  = patch_two_en_q;
  assign bus.tree_patch_in      = patch_in_q;
  assign bus.tree_patch_in_two  = patch_in_two_q;
  assign bus.res_valid          = res_gate & bus.tree_receiver_en;
  assign bus.res_valid_two      = res_gate & bus.tree_receiver_two_en;
  assign bus.res_idx            = (res_gate & bus.tree_receiver_en) ? head0.idx : '0;
  assign bus.res_idx_two        = (res_gate & bus.tree_receiver_two_en) ? head1.idx : '0;
  assign bus.res_leaf           = (res_gate & bus.tree_receiver_en) ? bus.tree_leaf_index : '0;
  assign bus.res_leaf_two       = (res_gate & bus.tree_receiver_two_en) ? bus.tree_leaf_index_two : '0;
  assign bus.busy               = busy;
  assign bus.done               = done;
  assign bus.err                = err_q;

endmodule

// File: tb/tb_kdtree_query_scheduler.sv
// tb/tb_kdtree_query_scheduler.sv - directed self-checking bench for kdtree_query_scheduler
module tb_kdtree_query_scheduler;
  import kdtree_pkg::*;

  localparam int TL = DEF_TREE_LATENCY;
  localparam int PW = DEF_PATCH_WIDTH;

  logic clk;
  logic rst_n;
  logic inj0;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   done_cnt;
  int   done_cyc;

  int                  iss_cyc[$];
  logic                iss_two[$];
  logic [PW-1:0]       iss_p0[$];
  logic [PW-1:0]       iss_p1[$];
  int                  r0_cyc[$];
  int                  r0_idx[$];
  int                  r0_leaf[$];
  int                  r1_cyc[$];
  int                  r1_idx[$];
  int                  r1_leaf[$];
  logic [21:0]         snd[$];

  kdtree_query_scheduler_if bus ();

  kdtree_query_scheduler dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural tree: echoes each lane's patch_en TL cycles later with leaf = patch[7:0]^A5.
  initial begin
    logic          en0_sh[TL];
    logic          en1_sh[TL];
    logic [PW-1:0] p0_sh[TL];
    logic [PW-1:0] p1_sh[TL];
    for (int i = 0; i < TL; i++) begin
      en0_sh[i] = 1'b0; en1_sh[i] = 1'b0; p0_sh[i] = '0; p1_sh[i] = '0;
    end
    bus.tree_receiver_en     = 1'b0;
    bus.tree_receiver_two_en = 1'b0;
    bus.tree_leaf_index      = '0;
    bus.tree_leaf_index_two  = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.tree_receiver_en     = en0_sh[TL-1] | inj0;
      bus.tree_leaf_index      = en0_sh[TL-1] ? (p0_sh[TL-1][7:0] ^ 8'hA5) : 8'h00;
      bus.tree_receiver_two_en = en1_sh[TL-1];
      bus.tree_leaf_index_two  = en1_sh[TL-1] ? (p1_sh[TL-1][7:0] ^ 8'hA5) : 8'h00;
      for (int i = TL - 1; i > 0; i--) begin
        en0_sh[i] = en0_sh[i-1]; en1_sh[i] = en1_sh[i-1];
        p0_sh[i]  = p0_sh[i-1];  p1_sh[i]  = p1_sh[i-1];
      end
      en0_sh[0] = bus.tree_patch_en;
      en1_sh[0] = bus.tree_patch_two_en;
      p0_sh[0]  = bus.tree_patch_in;
      p1_sh[0]  = bus.tree_patch_in_two;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.tree_patch_en) begin
        iss_cyc.push_back(cyc);
        iss_two.push_back(bus.tree_patch_two_en);
        iss_p0.push_back(bus.tree_patch_in);
        iss_p1.push_back(bus.tree_patch_in_two);
      end
      if (bus.res_valid) begin
        r0_cyc.push_back(cyc); r0_idx.push_back(int'(bus.res_idx)); r0_leaf.push_back(int'(bus.res_leaf));
      end
      if (bus.res_valid_two) begin
        r1_cyc.push_back(cyc); r1_idx.push_back(int'(bus.res_idx_two)); r1_leaf.push_back(int'(bus.res_leaf_two));
      end
      if (bus.done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (bus.tree_sender_enable) snd.push_back(bus.tree_sender_data);
    end
  end

  task automatic clear_logs();
    iss_cyc.delete(); iss_two.delete(); iss_p0.delete(); iss_p1.delete();
    r0_cyc.delete(); r0_idx.delete(); r0_leaf.delete();
    r1_cyc.delete(); r1_idx.delete(); r1_leaf.delete();
    snd.delete();
    done_cnt = 0;
    done_cyc = 0;
  endtask

  task automatic start_job(input int n);
    clear_logs();
    bus.start       = 1'b1;
    bus.num_queries = 12'(n);
    @(posedge clk); #1;
    bus.start       = 1'b0;
  endtask

  task automatic load_nodes();
    int   i = 0;
    int   g = 0;
    logic xfer;
    while (i < DEF_NUM_NODES && g < 400) begin
      bus.node_valid = ((g % 3) != 2);
      bus.node_data  = 22'h1000 + 22'(i);
      @(negedge clk);
      xfer = bus.node_valid && bus.node_ready;
      @(posedge clk); #1;
      if (xfer) i++;
      g++;
    end
    bus.node_valid = 1'b0;
    check_eq("load_xfers", 64'(i), 64'(DEF_NUM_NODES));
  endtask

  task automatic feed_queries(input int n, input logic [PW-1:0] base);
    int   i = 0;
    int   g = 0;
    logic xfer;
    while (i < n && g < 200) begin
      bus.q_valid = 1'b1;
      bus.q_data  = base + PW'(i);
      @(negedge clk);
      xfer = bus.q_ready;
      @(posedge clk); #1;
      if (xfer) i++;
      g++;
    end
    bus.q_valid = 1'b0;
    check_eq("feed_xfers", 64'(i), 64'(n));
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (done_cnt == 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_job(input string tag, input int n, input logic [PW-1:0] base);
    logic [PW-1:0] p;
    check_eq({tag, "_issues"}, 64'(iss_cyc.size()), 64'((n + 1) / 2));
    check_eq({tag, "_res0_cnt"}, 64'(r0_idx.size()), 64'((n + 1) / 2));
    check_eq({tag, "_res1_cnt"}, 64'(r1_idx.size()), 64'(n / 2));
    for (int k = 0; k < iss_cyc.size() && k < (n + 1) / 2; k++) begin
      check_eq({tag, "_p0"}, 64'(iss_p0[k]), 64'(base + PW'(2 * k)));
      check_eq({tag, "_two_en"}, 64'(iss_two[k]), 64'((2 * k + 1) < n));
      if ((2 * k + 1) < n) check_eq({tag, "_p1"}, 64'(iss_p1[k]), 64'(base + PW'(2 * k + 1)));
      if (k < r0_idx.size()) begin
        p = base + PW'(2 * k);
        check_eq({tag, "_r0_idx"}, 64'(r0_idx[k]), 64'(2 * k));
        check_eq({tag, "_r0_leaf"}, 64'(r0_leaf[k]), 64'(p[7:0] ^ 8'hA5));
        check_eq({tag, "_r0_lat"}, 64'(r0_cyc[k] - iss_cyc[k]), 64'(TL));
      end
      if (k < r1_idx.size()) begin
        p = base + PW'(2 * k + 1);
        check_eq({tag, "_r1_idx"}, 64'(r1_idx[k]), 64'(2 * k + 1));
        check_eq({tag, "_r1_leaf"}, 64'(r1_leaf[k]), 64'(p[7:0] ^ 8'hA5));
        check_eq({tag, "_r1_lat"}, 64'(r1_cyc[k] - iss_cyc[k]), 64'(TL));
      end
    end
    check_eq({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    check_eq({tag, "_err"}, 64'(bus.err), 64'd0);
    check_eq({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int load_end;
    int bad;
    n_checks = 0;
    n_errors = 0;
    inj0 = 1'b0;
    done_cnt = 0;
    done_cyc = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.num_queries = '0;
    bus.node_valid = 1'b0;
    bus.node_data = '0;
    bus.q_valid = 1'b0;
    bus.q_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_err", 64'(bus.err), 64'd0);
    check_eq("rst_outs", 64'({bus.node_ready, bus.q_ready, bus.tree_fsm_enable,
                              bus.tree_patch_en, bus.done, bus.res_valid}), 64'd0);

    // Job of 4 with node bubbles: 63 sender words in order, then two dual-lane issues.
    start_job(4);
    check_eq("load_busy", 64'(bus.busy), 64'd1);
    load_nodes();
    check_eq("snd_count", 64'(snd.size()), 64'd63);
    bad = 0;
    for (int i = 0; i < snd.size(); i++) if (snd[i] !== 22'h1000 + 22'(i)) bad++;
    check_eq("snd_order_bad", 64'(bad), 64'd0);
    check_eq("state_query", 64'(dut.state_q), 64'(ST_QUERY));
    check_eq("node_ready_off", 64'(bus.node_ready), 64'd0);
    feed_queries(4, 55'h100);
    wait_done("j4");
    check_job("j4", 4, 55'h100);

    // Job of 5: third issue is lane 0 alone carrying idx 4.
    start_job(5);
    load_nodes();
    feed_queries(5, 55'h2F0);
    wait_done("j5");
    check_job("j5", 5, 55'h2F0);
    if (r0_cyc.size() == 3) check_eq("j5_done_after_res", 64'(done_cyc > r0_cyc[2]), 64'd1);
    else check_eq("j5_res0_present", 64'(r0_cyc.size()), 64'd3);

    // Zero-query job: straight through to done, nothing issued.
    start_job(0);
    load_nodes();
    load_end = cyc;
    wait_done("j0");
    check_eq("j0_issues", 64'(iss_cyc.size()), 64'd0);
    check_eq("j0_done_lat", 64'(done_cyc - load_end), 64'd2);
    check_eq("j0_done_once", 64'(done_cnt), 64'd1);

    // Stray result with an empty tag pipe after a job: err is sticky until reset.
    inj0 = 1'b1;
    @(posedge clk); #1;
    inj0 = 1'b0;
    @(posedge clk); #1;
    check_eq("inj_err_set", 64'(bus.err), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check_eq("inj_err_held", 64'(bus.err), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("inj_err_cleared", 64'(bus.err), 64'd0);

    // Reset mid-QUERY with results in flight, then a fresh job.
    start_job(6);
    load_nodes();
    feed_queries(3, 55'h40);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("midq_rst_outs", 64'({bus.busy, bus.done, bus.err, bus.node_ready, bus.q_ready,
                                   bus.tree_fsm_enable, bus.tree_sender_enable, bus.tree_patch_en,
                                   bus.tree_patch_two_en, |bus.tree_patch_in, |bus.tree_patch_in_two,
                                   bus.res_valid, bus.res_valid_two}), 64'd0);
    check_eq("midq_rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_eq("midq_inflight_err", 64'(bus.err), 64'd0);
    start_job(2);
    load_nodes();
    feed_queries(2, 55'h7FE);
    wait_done("j2");
    check_job("j2", 2, 55'h7FE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
